rm_op_sched: RTL and testbench
==============================

# rm_op_sched

Operation scheduler for the reconfigurable arithmetic partition. It accepts operation requests (op code plus operands) over a valid/ready handshake and checks whether the reconfigurable module (RM) currently loaded in the partition implements that op. On a miss it requests a partial reconfiguration, decouples the partition and holds the RM in reset until the swap settles. It then drives the datapath, waits a fixed execution latency, and returns the result over a second valid/ready handshake. It sits between the PS-side command logic and the datapath op_sel/a/b/out nets, and owns the icap_reset line.

## Interface
- DATAWIDTH, 8, operand/result width
- OPW, 5, op code width (matches op_sel)
- MAX_OP, 10, highest legal op code; codes 0..MAX_OP each map to one RM
- EXEC_LAT, 2, cycles the datapath is held before dp_out is sampled (≥1)
- RST_HOLD, 4, cycles RM reset stays asserted after pr_done (≥1)
- PR_TIMEOUT, 1024, max cycles waiting for pr_done/pr_err
- clk  in  1  sole clock
- rst  in  1  synchronous, active-low reset
- req_valid / req_ready  in / out  1  request handshake
- req_op  in  OPW  requested op code
- req_a, req_b  in  DATAWIDTH  operands
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_data  out  DATAWIDTH  result; 0 when rsp_err
- rsp_err  out  1  illegal op, PR error or PR timeout
- pr_req  out  1  level request to reconfiguration engine
- pr_id  out  OPW  RM to load
- pr_done, pr_err  in  1  single-cycle completion/failure pulses
- decouple  out  1  partition isolation
- icap_reset  out  1  RM reset, active-high
- dp_op_sel  out  OPW;  dp_a, dp_b  out  DATAWIDTH;  dp_out  in  DATAWIDTH  datapath port
- cur_op  out  OPW;  cur_valid  out  1  loaded-RM status

## Operation
- States: IDLE, RECONF, SETTLE, EXEC, RESP.
- IDLE: req_ready=1. On accept, latch op/a/b.
  - op > MAX_OP → RESP, err=1, data=0.
  - cur_valid && op==cur_op → EXEC.
  - Otherwise → RECONF.
- RECONF: pr_req=1, pr_id=latched op, decouple=1, icap_reset=1. Timer counts cycles.
  - pr_err, or timer reaching PR_TIMEOUT → clear cur_valid, drop pr_req, → RESP with err=1.
  - pr_done → cur_op=op, cur_valid=1, → SETTLE.
  - pr_done and pr_err in the same cycle → treated as error.
- SETTLE: decouple=1, icap_reset=1 for RST_HOLD cycles, then → EXEC.
- EXEC: decouple=0, icap_reset=0. dp_op_sel/dp_a/dp_b are driven from the latched values for EXEC_LAT cycles. In the last EXEC cycle, capture dp_out into rsp_data, then → RESP.
- RESP: rsp_valid=1. rsp_data and rsp_err are held stable until rsp_ready; the cycle after the handshake → IDLE.
- dp_* outputs hold their last value outside EXEC. Only cur_op/cur_valid persist across requests.

## Timing
- Reset (rst=0 at an edge): state=IDLE. All outputs 0, including cur_valid, pr_req, decouple, icap_reset, rsp_valid. req_ready is 1 from the first cycle after reset.
- Reset mid-operation aborts immediately with the same values. An in-flight PR request is dropped, and no response is produced.
- Hit latency: accept edge E0 → EXEC in cycles 1..EXEC_LAT → rsp_valid from cycle EXEC_LAT+1.
- Miss latency: pr_req rises the cycle after accept. On pr_done sampled at edge Ed, SETTLE occupies RST_HOLD cycles, then EXEC_LAT cycles, then RESP.
- Illegal op: rsp_valid is high the cycle after accept.
- At most one request is outstanding; req_ready=0 outside IDLE.
- Timeout: the counter starts at 0 on RECONF entry and fires on the cycle it equals PR_TIMEOUT-1.
- Counter width: $clog2(max(PR_TIMEOUT, RST_HOLD, EXEC_LAT)+1).

## Structure
- Shared package rm_sched_pkg holds:
  - the state encoding;
  - op code constants (OP_ADD=0, OP_DEC=1, OP_DIV=2, OP_INC=3, OP_MOD=4, OP_MUL=5, OP_MUX=6, OP_REG=7, OP_SHL=8, OP_SHR=9, OP_SUB=10);
  - MAX_OP.
- One sub-module, sched_timer: a loadable up-counter with a terminal-count flag. It is shared by the RECONF, SETTLE and EXEC states and cleared on every state entry.

## Test plan
- Cold miss: after reset, request op=0, a=3, b=4. PR model pulses pr_done 5 cycles after pr_req. Required: pr_id=0, decouple/icap_reset high through SETTLE, rsp_data=7, rsp_err=0, cur_op=0, cur_valid=1.
- Hit: next request op=0, a=10, b=20. Required: no pr_req; rsp_valid exactly EXEC_LAT+1 cycles after accept; rsp_data=30.
- Illegal op: request op=15. Required: rsp_valid the next cycle, rsp_err=1, rsp_data=0, no pr_req, cur_op/cur_valid unchanged.
- Timeout: request op=5 and never pulse pr_done. Required: after PR_TIMEOUT cycles pr_req=0, rsp_err=1, cur_valid=0. A following op=0 request must reload.
- Error and backpressure: pr_done and pr_err pulse in the same cycle. Required: rsp_err=1. Hold rsp_ready=0 for 6 cycles: rsp_data and rsp_err stay stable and req_ready stays 0.
- Reset mid-RECONF: drive rst=0 for one edge while pr_req=1. Required: all outputs 0 next cycle, cur_valid=0, no response, req_ready=1 afterwards.

Source files
------------

// File: rtl/rm_sched_pkg.sv
// ============================================================================
// Module      : rm_sched_pkg
// Description : Shared scheduler state encoding and RM op code map.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rm_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RECONF = 3'd1,
        S_SETTLE = 3'd2,
        S_EXEC   = 3'd3,
        S_RESP   = 3'd4
    } sched_state_e;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_DEC = 5'd1;
    localparam logic [4:0] OP_DIV = 5'd2;
    localparam logic [4:0] OP_INC = 5'd3;
    localparam logic [4:0] OP_MOD = 5'd4;
    localparam logic [4:0] OP_MUL = 5'd5;
    localparam logic [4:0] OP_MUX = 5'd6;
    localparam logic [4:0] OP_REG = 5'd7;
    localparam logic [4:0] OP_SHL = 5'd8;
    localparam logic [4:0] OP_SHR = 5'd9;
    localparam logic [4:0] OP_SUB = 5'd10;

    localparam int MAX_OP = 10;

    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sched_timer.sv
// ============================================================================
// Module      : sched_timer
// Description : Clearable up-counter with terminal-count flag; holds at term.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sched_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !tc_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

`default_nettype wire

// File: rtl/rm_op_sched.sv
// ============================================================================
// Module      : rm_op_sched
// Description : Op scheduler for the reconfigurable arithmetic partition.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rm_op_sched #(
    parameter int DATAWIDTH  = 8,
    parameter int OPW        = 5,
    parameter int MAX_OP     = rm_sched_pkg::MAX_OP,
    parameter int EXEC_LAT   = 2,
    parameter int RST_HOLD   = 4,
    parameter int PR_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [OPW-1:0]       req_op,
    input  logic [DATAWIDTH-1:0] req_a,
    input  logic [DATAWIDTH-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATAWIDTH-1:0] rsp_data,
    output logic                 rsp_err,
    output logic                 pr_req,
    output logic [OPW-1:0]       pr_id,
    input  logic                 pr_done,
    input  logic                 pr_err,
    output logic                 decouple,
    output logic                 icap_reset,
    output logic [OPW-1:0]       dp_op_sel,
    output logic [DATAWIDTH-1:0] dp_a,
    output logic [DATAWIDTH-1:0] dp_b,
    input  logic [DATAWIDTH-1:0] dp_out,
    output logic [OPW-1:0]       cur_op,
    output logic                 cur_valid
);

    import rm_sched_pkg::*;

    localparam int             CNT_W     = $clog2(max3(PR_TIMEOUT, RST_HOLD, EXEC_LAT) + 1);
    localparam logic [CNT_W-1:0] T_PR    = CNT_W'(PR_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] T_SETTLE = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] T_EXEC  = CNT_W'(EXEC_LAT - 1);
    localparam logic [OPW-1:0] MAX_OP_V  = OPW'(MAX_OP);

    sched_state_e          state_q, state_d;
    logic [OPW-1:0]        op_q, op_d;
    logic [DATAWIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [OPW-1:0]        cur_op_q, cur_op_d;
    logic                  cur_valid_q, cur_valid_d;
    logic [DATAWIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [OPW-1:0]        dp_op_q;
    logic [DATAWIDTH-1:0]  dp_a_q, dp_b_q;

    logic                  w_tc;
    logic                  w_tmr_en;
    logic [CNT_W-1:0]      w_term;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cur_op_q    <= '0;
            cur_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            dp_op_q     <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cur_op_q    <= cur_op_d;
            cur_valid_q <= cur_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            // Datapath is loaded on the edge into EXEC so it is valid from the first EXEC cycle
            if (state_d == S_EXEC) begin
                dp_op_q <= op_d;
                dp_a_q  <= a_d;
                dp_b_q  <= b_d;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        cur_op_d    = cur_op_q;
        cur_valid_d = cur_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        w_term      = '0;
        w_tmr_en    = 1'b0;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        pr_req      = 1'b0;
        decouple    = 1'b0;
        icap_reset  = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d = req_op;
                    a_d  = req_a;
                    b_d  = req_b;
                    if (req_op > MAX_OP_V) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = S_RESP;
                    end else if (cur_valid_q && (req_op == cur_op_q)) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_RECONF;
                    end
                end
            end
            S_RECONF: begin
                pr_req     = 1'b1;
                decouple   = 1'b1;
                icap_reset = 1'b1;
                w_term     = T_PR;
                w_tmr_en   = 1'b1;
                // A coincident pr_done/pr_err is resolved as a failure
                if (pr_err || w_tc) begin
                    cur_valid_d = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = S_RESP;
                end else if (pr_done) begin
                    cur_op_d    = op_q;
                    cur_valid_d = 1'b1;
                    state_d     = S_SETTLE;
                end
            end
            S_SETTLE: begin
                decouple   = 1'b1;
                icap_reset = 1'b1;
                w_term     = T_SETTLE;
                w_tmr_en   = 1'b1;
                if (w_tc) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                w_term   = T_EXEC;
                w_tmr_en = 1'b1;
                if (w_tc) begin
                    rsp_data_d = dp_out;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    sched_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_d != state_q),
        .en_i   (w_tmr_en),
        .term_i (w_term),
        .tc_o   (w_tc)
    );

    assign pr_id     = op_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign dp_op_sel = dp_op_q;
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign cur_op    = cur_op_q;
    assign cur_valid = cur_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_rm_op_sched.sv
// ============================================================================
// Module      : tb_rm_op_sched
// Description : Self-checking bench: directed vector table plus random requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rm_op_sched;
    import rm_sched_pkg::*;

    localparam int DW = 8;
    localparam int OW = 5;
    localparam int EXEC_LAT = 2;
    localparam int RST_HOLD = 4;
    localparam int PR_TIMEOUT = 1024;
    localparam int M_DONE = 0, M_ERR = 1, M_BOTH = 2, M_NEVER = 3;

    logic clk = 1'b0;
    logic rst;
    logic req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [OW-1:0] req_op, pr_id, dp_op_sel, cur_op;
    logic [DW-1:0] req_a, req_b, rsp_data, dp_a, dp_b, dp_out;
    logic pr_req, pr_done, pr_err, decouple, icap_reset, cur_valid;

    int n_cmp = 0;
    int n_bad = 0;
    int pr_mode = M_NEVER;
    int pr_delay = 0;
    int pr_age = 0;
    logic [OW-1:0] m_cop;
    logic m_cv;

    typedef struct {
        logic [OW-1:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int mode;
        int delay;
        int hold;
        logic [DW-1:0] exp_data;
        logic exp_err;
        int exp_lat;
        int exp_dec;
        logic exp_pr;
        logic [OW-1:0] exp_cop;
        logic exp_cv;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dp_fn(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        case (op)
            OP_ADD: return a + b;
            OP_DEC: return a - 8'd1;
            OP_DIV: return (b == 0) ? 8'd0 : a / b;
            OP_INC: return a + 8'd1;
            OP_MOD: return (b == 0) ? 8'd0 : a % b;
            OP_MUL: return 8'(a * b);
            OP_MUX: return b[0] ? a : b;
            OP_REG: return a;
            OP_SHL: return a << b[2:0];
            OP_SHR: return a >> b[2:0];
            OP_SUB: return a - b;
            default: return 8'd0;
        endcase
    endfunction

    assign dp_out = dp_fn(dp_op_sel, dp_a, dp_b);

    rm_op_sched #(
        .DATAWIDTH(DW), .OPW(OW), .MAX_OP(10), .EXEC_LAT(EXEC_LAT),
        .RST_HOLD(RST_HOLD), .PR_TIMEOUT(PR_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .pr_req(pr_req), .pr_id(pr_id), .pr_done(pr_done), .pr_err(pr_err),
        .decouple(decouple), .icap_reset(icap_reset),
        .dp_op_sel(dp_op_sel), .dp_a(dp_a), .dp_b(dp_b), .dp_out(dp_out),
        .cur_op(cur_op), .cur_valid(cur_valid)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One clock; afterwards the reconfiguration engine model reacts to pr_req
    task automatic step();
        @(posedge clk);
        #1;
        pr_done = 1'b0;
        pr_err  = 1'b0;
        if (pr_req) begin
            pr_age++;
            if (pr_age == pr_delay) begin
                pr_done = (pr_mode == M_DONE) || (pr_mode == M_BOTH);
                pr_err  = (pr_mode == M_ERR)  || (pr_mode == M_BOTH);
            end
        end else begin
            pr_age = 0;
        end
    endtask

    task automatic run_txn(input vec_t v);
        int w;
        int n;
        int dec;
        logic pr_seen;
        logic id_bad;
        logic rdy_bad;
        w = 0;
        while (!req_ready && w < 20) begin
            step();
            w++;
        end
        chk("req_ready_idle", req_ready, 1);
        pr_mode = v.mode;
        pr_delay = v.delay;
        req_valid = 1'b1;
        req_op = v.op;
        req_a = v.a;
        req_b = v.b;
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        n = 1;
        dec = 0;
        pr_seen = 1'b0;
        id_bad = 1'b0;
        rdy_bad = 1'b0;
        while (!rsp_valid && n <= PR_TIMEOUT + 64) begin
            if (pr_req) begin
                pr_seen = 1'b1;
                if (pr_id !== v.op) id_bad = 1'b1;
            end
            if (decouple && icap_reset) dec++;
            if (req_ready) rdy_bad = 1'b1;
            step();
            n++;
        end
        chk("rsp_latency", n, v.exp_lat);
        chk("rsp_data", rsp_data, v.exp_data);
        chk("rsp_err", rsp_err, v.exp_err);
        chk("pr_req_seen", pr_seen, v.exp_pr);
        chk("pr_id_bad", id_bad, 0);
        chk("decouple_cycles", dec, v.exp_dec);
        chk("req_ready_busy", rdy_bad, 0);
        for (int h = 0; h < v.hold; h++) begin
            step();
            chk("backpressure_hold", {rsp_valid, req_ready, rsp_err, rsp_data},
                {1'b1, 1'b0, v.exp_err, v.exp_data});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("after_handshake", {rsp_valid, req_ready}, 2'b01);
        chk("cur_op", cur_op, v.exp_cop);
        chk("cur_valid", cur_valid, v.exp_cv);
    endtask

    // Reference model: derives the expected response from the scheduling rules
    function automatic vec_t model(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b, input int mode, input int delay,
                                   input int hold);
        vec_t v;
        v = '{op, a, b, mode, delay, hold, 8'd0, 1'b0, 0, 0, 1'b0, 5'd0, 1'b0};
        if (op > 10) begin
            v.exp_err = 1'b1;
            v.exp_lat = 1;
        end else if (m_cv && op == m_cop) begin
            v.exp_data = dp_fn(op, a, b);
            v.exp_lat = EXEC_LAT + 1;
        end else begin
            v.exp_pr = 1'b1;
            if (mode == M_DONE) begin
                v.exp_data = dp_fn(op, a, b);
                v.exp_lat = delay + RST_HOLD + EXEC_LAT + 1;
                v.exp_dec = delay + RST_HOLD;
                m_cop = op;
                m_cv = 1'b1;
            end else begin
                v.exp_err = 1'b1;
                v.exp_lat = delay + 1;
                v.exp_dec = delay;
                m_cv = 1'b0;
            end
        end
        v.exp_cop = m_cop;
        v.exp_cv = m_cv;
        return v;
    endfunction

    initial begin
        logic flag;
        int r;
        vec_t v;
        rst = 1'b0;
        req_valid = 1'b0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        pr_done = 1'b0;
        pr_err = 1'b0;
        step();
        step();
        chk("reset_ctrl", {pr_req, decouple, icap_reset, rsp_valid, rsp_err, cur_valid}, 0);
        chk("reset_data", {rsp_data, cur_op, pr_id, dp_op_sel, dp_a, dp_b}, 0);
        rst = 1'b1;
        step();
        chk("reset_req_ready", req_ready, 1);

        //           op     a      b      mode    dly hold data   err lat  dec  pr  cop  cv
        tbl[0] = '{5'd0, 8'd3, 8'd4, M_DONE, 5, 0, 8'd7, 1'b0, 12, 9, 1'b1, 5'd0, 1'b1};
        tbl[1] = '{5'd0, 8'd10, 8'd20, M_DONE, 5, 0, 8'd30, 1'b0, 3, 0, 1'b0, 5'd0, 1'b1};
        tbl[2] = '{5'd15, 8'd1, 8'd2, M_DONE, 5, 0, 8'd0, 1'b1, 1, 0, 1'b0, 5'd0, 1'b1};
        tbl[3] = '{5'd5, 8'd9, 8'd9, M_NEVER, 0, 0, 8'd0, 1'b1, 1025, 1024, 1'b1, 5'd0, 1'b0};
        tbl[4] = '{5'd0, 8'd7, 8'd8, M_DONE, 3, 0, 8'd15, 1'b0, 10, 7, 1'b1, 5'd0, 1'b1};
        tbl[5] = '{5'd3, 8'd1, 8'd1, M_BOTH, 4, 6, 8'd0, 1'b1, 5, 4, 1'b1, 5'd0, 1'b0};
        tbl[6] = '{5'd5, 8'd6, 8'd7, M_DONE, 1, 2, 8'd42, 1'b0, 8, 5, 1'b1, 5'd5, 1'b1};
        tbl[7] = '{5'd5, 8'd20, 8'd13, M_DONE, 1, 0, 8'd4, 1'b0, 3, 0, 1'b0, 5'd5, 1'b1};
        for (int i = 0; i < 8; i++) run_txn(tbl[i]);

        // Reset while a reconfiguration is in flight
        pr_mode = M_NEVER;
        req_valid = 1'b1;
        req_op = 5'd9;
        req_a = 8'd1;
        req_b = 8'd1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 5 && !pr_req; i++) step();
        chk("midrst_pr_req_up", pr_req, 1);
        step();
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_ctrl", {pr_req, decouple, icap_reset, rsp_valid, rsp_err, cur_valid}, 0);
        chk("midrst_data", {rsp_data, cur_op, pr_id, dp_op_sel, dp_a, dp_b}, 0);
        chk("midrst_req_ready", req_ready, 1);
        flag = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rsp_valid || pr_req || !req_ready) flag = 1'b1;
        end
        chk("midrst_quiet", flag, 0);
        m_cop = '0;
        m_cv = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic [OW-1:0] op;
            int mode;
            r = $urandom_range(0, 9);
            if (r == 0)      op = OW'($urandom_range(11, 31));
            else if (r < 7)  op = OW'($urandom_range(0, 3));
            else             op = OW'($urandom_range(0, 10));
            r = $urandom_range(0, 9);
            mode = (r < 7) ? M_DONE : ((r < 9) ? M_ERR : M_BOTH);
            v = model(op, 8'($urandom), 8'($urandom), mode, $urandom_range(1, 6),
                      $urandom_range(0, 3));
            run_txn(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
